// File: rtl/pwl_pkg.sv
// Shared types and fixed-point helpers for the piecewise-linear jerk oscillator.
// SATURATE_EN: when defined, every sum, difference and truncated product clamps
// to the signed range of the word width; otherwise results wrap modulo 2^Width.
// Helpers operate on 64-bit signed carriers, so word widths up to 32 bits are supported.
package pwl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef logic signed [63:0] wide_t;

   // Fixed-point 1.0 for a given number of fraction bits.
   function automatic wide_t fx_one(input int frac);
      fx_one = wide_t'(64'sd1) <<< frac;
   endfunction

   // Bring a wide intermediate back into the signed range of a w-bit word.
`ifdef SATURATE_EN
   function automatic wide_t fx_fit(input wide_t v, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(64'sd1) <<< (w - 1)) - wide_t'(64'sd1);
      lo = -hi - wide_t'(64'sd1);
      if (v > hi)
         fx_fit = hi;
      else if (v < lo)
         fx_fit = lo;
      else
         fx_fit = v;
   endfunction
`else
   function automatic wide_t fx_fit(input wide_t v, input int w);
      fx_fit = (v <<< (64 - w)) >>> (64 - w);
   endfunction
`endif

   function automatic wide_t fx_add(input wide_t a, input wide_t b, input int w);
      fx_add = fx_fit(a + b, w);
   endfunction

   function automatic wide_t fx_sub(input wide_t a, input wide_t b, input int w);
      fx_sub = fx_fit(a - b, w);
   endfunction

   // Full-precision product, floor shift by frac, then fit to w bits.
   function automatic wide_t fx_mul(input wide_t a, input wide_t b, input int w, input int frac);
      fx_mul = fx_fit((a * b) >>> frac, w);
   endfunction

   // |a|; the most-negative word wraps to itself or clamps to most-positive.
   function automatic wide_t fx_abs(input wide_t a, input int w);
      fx_abs = (a < 0) ? fx_fit(-a, w) : a;
   endfunction

endpackage

// File: rtl/pwl_step.sv
// One Euler step of the jerk system, purely combinational:
//   x' = x + h*y,  y' = y + h*z,  z' = z + h*(|x| - 1 - y - a*z)
// All three updates read the pre-step values. Overflow handling follows SATURATE_EN.
module pwl_step
   import pwl_pkg::*;
#(
   parameter int Width = 16,
   parameter int Frac  = 13
) (
   input  logic signed [Width-1:0] x,
   input  logic signed [Width-1:0] y,
   input  logic signed [Width-1:0] z,
   input  logic signed [Width-1:0] h,
   input  logic signed [Width-1:0] a,
   output logic signed [Width-1:0] x_next,
   output logic signed [Width-1:0] y_next,
   output logic signed [Width-1:0] z_next
);

   wide_t xw, yw, zw, hw, aw;
   wide_t jerk;

   assign xw = wide_t'(x);
   assign yw = wide_t'(y);
   assign zw = wide_t'(z);
   assign hw = wide_t'(h);
   assign aw = wide_t'(a);

   // Evaluated left to right so saturation points are well defined.
   assign jerk = fx_sub(fx_sub(fx_sub(fx_abs(xw, Width), fx_one(Frac), Width),
                               yw, Width),
                        fx_mul(aw, zw, Width, Frac), Width);

   assign x_next = Width'(fx_add(xw, fx_mul(hw, yw, Width, Frac), Width));
   assign y_next = Width'(fx_add(yw, fx_mul(hw, zw, Width, Frac), Width));
   assign z_next = Width'(fx_add(zw, fx_mul(hw, jerk, Width, Frac), Width));

endmodule

// File: rtl/pwl_chaos_osc.sv
// Piecewise-linear jerk oscillator: IDLE -> LOAD -> RUN -> DONE sequencer around
// pwl_step, with shadowed parameters, iteration budget and output decimation.
// Optional SATURATE_EN selects clamping instead of wrapping arithmetic.
// Handshake: start_i is honoured only in IDLE; stop_i only in RUN, where the step
// of that cycle still completes. valid_o is a one-cycle strobe aligned with a
// decimated sample on xn/yn/zn; done_o is a one-cycle strobe in the cycle after
// the DONE state, when busy_o has just dropped.
module pwl_chaos_osc
   import pwl_pkg::*;
#(
   parameter int Width = 16,
   parameter int Frac  = 13,
   parameter int IterW = 16,
   parameter int DecW  = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic signed [Width-1:0] h_i,
   input  logic signed [Width-1:0] a_i,
   input  logic signed [Width-1:0] x0_i,
   input  logic signed [Width-1:0] y0_i,
   input  logic signed [Width-1:0] z0_i,
   input  logic [IterW-1:0]        n_iter_i,
   input  logic [DecW-1:0]         dec_i,
   output logic                    busy_o,
   output logic                    valid_o,
   output logic                    done_o,
   output logic [IterW-1:0]        iter_o,
   output logic signed [Width-1:0] xn_o,
   output logic signed [Width-1:0] yn_o,
   output logic signed [Width-1:0] zn_o,
   output state_t                  state_o
);

   state_t                  state;
   logic signed [Width-1:0] h_q, a_q;
   logic [IterW-1:0]        n_q;
   logic [DecW-1:0]         d_q;
   logic [DecW-1:0]         dec_cnt;
   logic signed [Width-1:0] x_nx, y_nx, z_nx;
   logic [IterW-1:0]        iter_inc;
   logic                    dec_last;
   logic                    budget_hit;

   pwl_step #(
      .Width (Width),
      .Frac  (Frac)
   ) u_step (
      .x      (xn_o),
      .y      (yn_o),
      .z      (zn_o),
      .h      (h_q),
      .a      (a_q),
      .x_next (x_nx),
      .y_next (y_nx),
      .z_next (z_nx)
   );

   assign iter_inc   = iter_o + IterW'(1);
   assign dec_last   = (dec_cnt == d_q - DecW'(1));
   assign budget_hit = (n_q != '0) && (iter_inc == n_q);
   assign state_o    = state;

   // Sequencer, shadow registers, state registers and strobes.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= ST_IDLE;
         h_q     <= '0;
         a_q     <= '0;
         n_q     <= '0;
         d_q     <= '0;
         dec_cnt <= '0;
         iter_o  <= '0;
         xn_o    <= '0;
         yn_o    <= '0;
         zn_o    <= '0;
         busy_o  <= 1'b0;
         valid_o <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         busy_o  <= (state == ST_LOAD) || (state == ST_RUN);
         done_o  <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start_i)
                  state <= ST_LOAD;
            end
            ST_LOAD: begin
               h_q     <= h_i;
               a_q     <= a_i;
               n_q     <= n_iter_i;
               d_q     <= (dec_i == '0) ? DecW'(1) : dec_i;
               xn_o    <= x0_i;
               yn_o    <= y0_i;
               zn_o    <= z0_i;
               iter_o  <= '0;
               dec_cnt <= '0;
               state   <= ST_RUN;
            end
            ST_RUN: begin
               xn_o   <= x_nx;
               yn_o   <= y_nx;
               zn_o   <= z_nx;
               iter_o <= iter_inc;
               if (dec_last) begin
                  dec_cnt <= '0;
                  valid_o <= 1'b1;
               end else begin
                  dec_cnt <= dec_cnt + DecW'(1);
               end
               if (stop_i || budget_hit)
                  state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwl_chaos_osc.sv
// Bench for pwl_chaos_osc (Width 16, Frac 13): hand-written latency/reset
// sequences plus a table of runs checked against an integer model via a queue.
module tb_pwl_chaos_osc;
   import pwl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] h = '0, a = '0, x0 = '0, y0 = '0, z0 = '0;
   logic [15:0] n_iter = '0;
   logic [7:0]  dec = '0;
   logic        busy, valid, done;
   logic [15:0] iter, xn, yn, zn;
   state_t      st;

   int checks = 0;
   int errors = 0;
   logic [47:0] exp_q[$];

   typedef struct {
      logic [15:0] h, a, x0, y0, z0, n;
      logic [7:0]  d;
      int          stop_at;
      int          steps;
      logic [15:0] ex, ey, ez;
      int          nvalid;
   } vec_t;

   vec_t vecs[7];

   pwl_chaos_osc dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .stop_i   (stop),
      .h_i      (h),
      .a_i      (a),
      .x0_i     (x0),
      .y0_i     (y0),
      .z0_i     (z0),
      .n_iter_i (n_iter),
      .dec_i    (dec),
      .busy_o   (busy),
      .valid_o  (valid),
      .done_o   (done),
      .iter_o   (iter),
      .xn_o     (xn),
      .yn_o     (yn),
      .zn_o     (zn),
      .state_o  (st)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // integer model of 16-bit Q2.13 arithmetic
   function automatic int fix(input longint v);
      longint m;
`ifdef SATURATE_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
`else
      m = v & 64'h0000_0000_0000_FFFF;
      return (m >= 32768) ? int'(m - 65536) : int'(m);
`endif
   endfunction

   function automatic int mul(input int p, input int q);
      longint pr;
      pr = longint'(p) * longint'(q);
      return fix(pr >>> 13);
   endfunction

   function automatic void model_step(inout int x, inout int y, inout int z,
                                      input int hh, input int aa);
      int ax, t, nx, ny, nz;
      ax = fix((x < 0) ? -longint'(x) : longint'(x));
      t  = fix(longint'(ax) - 8192);
      t  = fix(longint'(t) - longint'(y));
      t  = fix(longint'(t) - longint'(mul(aa, z)));
      nx = fix(longint'(x) + longint'(mul(hh, y)));
      ny = fix(longint'(y) + longint'(mul(hh, z)));
      nz = fix(longint'(z) + longint'(mul(hh, t)));
      x = nx;
      y = ny;
      z = nz;
   endfunction

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic vec_t mk(input logic [15:0] hh, aa, xx, yy, zz, nn,
                               input logic [7:0] dd, input int stop_at);
      vec_t v;
      int x, y, z, dv;
      v.h = hh; v.a = aa; v.x0 = xx; v.y0 = yy; v.z0 = zz; v.n = nn; v.d = dd;
      v.stop_at = stop_at;
      if (stop_at >= 0 && (nn == 0 || stop_at + 1 < int'(nn)))
         v.steps = stop_at + 1;
      else
         v.steps = int'(nn);
      dv = (dd == 0) ? 1 : int'(dd);
      x = s16(xx); y = s16(yy); z = s16(zz);
      for (int k = 0; k < v.steps; k++)
         model_step(x, y, z, s16(hh), s16(aa));
      v.ex = x[15:0]; v.ey = y[15:0]; v.ez = z[15:0];
      v.nvalid = v.steps / dv;
      return v;
   endfunction

   // driver + monitor for one run; expected samples queued up front
   task automatic run(input vec_t v, input string tag);
      int x, y, z, dv, bc, dc, vc, tail;
      bit seen_done, stop_done;
      logic [47:0] e;
      dv = (v.d == 0) ? 1 : int'(v.d);
      x = s16(v.x0); y = s16(v.y0); z = s16(v.z0);
      for (int k = 1; k <= v.steps; k++) begin
         model_step(x, y, z, s16(v.h), s16(v.a));
         if (k % dv == 0) exp_q.push_back({x[15:0], y[15:0], z[15:0]});
      end
      @(negedge clk);
      h = v.h; a = v.a; x0 = v.x0; y0 = v.y0; z0 = v.z0; n_iter = v.n; dec = v.d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; dc = 0; vc = 0; tail = 0; seen_done = 1'b0; stop_done = 1'b0;
      for (int cyc = 1; cyc <= 300 && tail < 3; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         stop = 1'b0;
         if (busy) bc++;
         if (valid) begin
            vc++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL %s_extra_valid: got sample %0h expected none", tag, {xn, yn, zn});
            end else begin
               e = exp_q.pop_front();
               check({tag, "_sample"}, {xn, yn, zn}, e);
            end
         end
         if (done) begin dc++; seen_done = 1'b1; end
         if (seen_done) tail++;
         // mid-run poke: restart request and new parameters must be ignored
         if (cyc == 3 && busy && !seen_done) begin
            start = 1'b1;
            h = 16'($urandom_range(0, 65535)); a = 16'($urandom_range(0, 65535));
            x0 = 16'($urandom_range(0, 65535)); n_iter = 16'($urandom_range(1, 3));
            dec = 8'($urandom_range(1, 9));
         end
         if (!stop_done && v.stop_at >= 0 && busy && int'(iter) == v.stop_at) begin
            stop = 1'b1;
            stop_done = 1'b1;
         end
      end
      check({tag, "_done_seen"}, seen_done, 1);
      check({tag, "_done_count"}, dc, 1);
      check({tag, "_busy_cycles"}, bc, v.steps + 1);
      check({tag, "_valid_count"}, vc, v.nvalid);
      check({tag, "_queue_left"}, exp_q.size(), 0);
      exp_q.delete();
      check({tag, "_iter"}, iter, v.steps[15:0]);
      check({tag, "_final_xyz"}, {xn, yn, zn}, {v.ex, v.ey, v.ez});
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      logic [15:0] t6_exp;
      int done_seen;
      vec_t t6;

      vecs[0] = mk(16'h0400, 16'h1666, 16'h0800, 16'hFC00, 16'h0200, 16'd10, 8'd4, -1);
      vecs[1] = mk(16'h0200, 16'h1000, 16'h1000, 16'h0100, 16'hFF00, 16'd25, 8'd1, -1);
      vecs[2] = mk(16'h0800, 16'h2000, 16'h8000, 16'h4000, 16'h7000, 16'd7, 8'd3, -1);
      vecs[3] = mk(16'h0400, 16'h1666, 16'h0800, 16'h0400, 16'hFC00, 16'd0, 8'd2, 5);
      vecs[4] = mk(16'h0300, 16'h0800, 16'h0100, 16'h0200, 16'h0300, 16'd4, 8'd0, 3);
      for (int i = 5; i < 7; i++)
         vecs[i] = mk(16'($urandom_range(0, 16'h0FFF)), 16'($urandom_range(0, 16'h3FFF)),
                      16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                      16'($urandom_range(0, 65535)), 16'($urandom_range(1, 40)),
                      8'($urandom_range(0, 5)), -1);

      // reset state
      repeat (2) @(negedge clk);
      check("rst_outputs", {busy, valid, done, iter, xn, yn, zn}, 0);
      check("rst_state", st, ST_IDLE);
      rst = 1'b1;

      // stop while idle is ignored
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("idle_stop", {st, busy, done}, {ST_IDLE, 2'b00});

      // first-step latency
      h = 16'h0400; a = 16'h1666; x0 = '0; y0 = '0; z0 = '0; n_iter = 16'd1; dec = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t1_e0_state", st, ST_LOAD);
      @(negedge clk);
      check("t1_e1_xyz", {xn, yn, zn}, 48'h0);
      check("t1_e1_flags", {busy, valid, done, iter}, {3'b100, 16'd0});
      @(negedge clk);
      check("t1_e2_xyz", {xn, yn, zn}, {16'h0000, 16'h0000, 16'hFC00});
      check("t1_e2_flags", {busy, valid, done, iter}, {3'b110, 16'd1});
      @(negedge clk);
      check("t1_e3_flags", {busy, valid, done, iter}, {3'b001, 16'd1});
      @(negedge clk);
      check("t1_e4_done", done, 0);

      // table of runs
      for (int i = 0; i < 7; i++)
         run(vecs[i], $sformatf("vec%0d", i));

      // overflow of x + h*y
      t6 = mk(16'h2000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'd1, 8'd1, -1);
      run(t6, "t6");
`ifdef SATURATE_EN
      t6_exp = 16'h7FFF;
`else
      t6_exp = 16'hFFFE;
`endif
      check("t6_xn_const", xn, t6_exp);

      // asynchronous reset mid-run
      @(negedge clk);
      h = 16'h0400; a = 16'h1666; x0 = 16'h0800; y0 = 16'h0400; z0 = 16'hFC00;
      n_iter = 16'd0; dec = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_running", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_outputs", {busy, valid, done, iter, xn, yn, zn}, 0);
      check("t5_rst_state", st, ST_IDLE);
      @(negedge clk);
      #2 rst = 1'b1;
      done_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("t5_no_done", done_seen, 0);
      check("t5_idle", {st, iter}, {ST_IDLE, 16'd0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
